cpu_mem_responder: RTL

//   Memory-side responder for the accumulator CPU's phase-sequenced bus. Consumes the

---
 rtl/cpu_pkg.sv | 29 ++
 rtl/cpu_sp_ram.sv | 57 +++++
 rtl/cpu_mem_responder.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
//   Shared constants for the accumulator CPU and its memory responder:
//   instruction opcodes, default bus widths and the controller phase count.
//   No ports; imported by the RAM and the responder.
// ---------------------------------------------------------------------------
package cpu_pkg;

  // Opcode field of the instruction register
  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  // Default address / data widths of the program/data RAM
  localparam int CPU_AW = 5;
  localparam int CPU_DW = 8;

  // Number of controller phases per instruction
  localparam int CPU_PHASES = 8;

  // Wait-state counter width (covers 0..7 extra clocks)
  localparam int WAIT_CNT_W = 3;

endpackage

// File: rtl/cpu_sp_ram.sv
// ---------------------------------------------------------------------------
// cpu_sp_ram
//   Synchronous RAM with one write port and one registered read port.
//   A read of the address being written on the same edge returns the new data.
//   Contents are not reset.
// Ports
//   clk    in   rising-edge clock
//   we     in   write enable; mem[waddr] <= wdata
//   waddr  in   AW  write address
//   wdata  in   DW  write data
//   re     in   read enable; rdata <= mem[raddr]
//   raddr  in   AW  read address
//   rdata  out  DW  registered read data (holds when re=0)
// ---------------------------------------------------------------------------
module cpu_sp_ram
  import cpu_pkg::*;
#(
  parameter int AW = CPU_AW,
  parameter int DW = CPU_DW
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rdata_q;
  logic [DW-1:0] rdata_d;

  // Write-first bypass so a read racing a store sees the stored value.
  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      if (we && (waddr == raddr)) begin
        rdata_d = wdata;
      end else begin
        rdata_d = mem[raddr];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/cpu_mem_responder.sv
// ---------------------------------------------------------------------------
// cpu_mem_responder
//   Memory-side responder for the phase-sequenced accumulator CPU bus.
//   Reads start on a rising edge of rd, optionally pass through WAIT_STATES
//   wait clocks, then present registered data with rvalid while rd stays high.
//   Stores commit on a rising edge of wr to mem[ir_addr].
// Ports
//   clk, rst   clock and synchronous active-high reset
//   sel        1 = pc_addr (fetch), 0 = ir_addr (operand) for reads
//   rd, wr     read / write strobes (edge-detected internally)
//   data_e     accumulator drives the bus; a store without it is an error
//   halt       blocks acceptance of new requests
//   pc_addr    program counter address
//   ir_addr    IR operand address (reads with sel=0, and all stores)
//   wdata      store data
//   rdata      read data, zero whenever rvalid=0
//   rvalid     rdata valid for the current read window
//   busy       read in progress (WAIT or DATA)
//   err        sticky protocol error, cleared only by rst
//   dbg_state  current responder state (0=IDLE, 1=WAIT, 2=DATA)
//
// Handshake: a read is requested by raising rd and holding it; the window is
//   owned by the requester. rvalid rises WAIT_STATES+1 clocks after the edge
//   that first samples rd high and stays high until rd falls; dropping rd at
//   any time ends (or aborts) the read on that edge. A new read needs rd low
//   for at least one clock.
// ---------------------------------------------------------------------------
module cpu_mem_responder
  import cpu_pkg::*;
#(
  parameter int AW          = CPU_AW,
  parameter int DW          = CPU_DW,
  parameter int WAIT_STATES = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sel,
  input  logic          rd,
  input  logic          wr,
  input  logic          data_e,
  input  logic          halt,
  input  logic [AW-1:0] pc_addr,
  input  logic [AW-1:0] ir_addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          rvalid,
  output logic          busy,
  output logic          err,
  output logic [1:0]    dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  localparam logic [WAIT_CNT_W-1:0] WS_INIT = WAIT_CNT_W'(WAIT_STATES);

  state_e                state_q, state_d;
  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
  logic [AW-1:0]         addr_q, addr_d;
  logic                  rd_q, wr_q;
  logic                  rvalid_q, rvalid_d;
  logic                  err_q, err_d;

  logic                  rd_rise;
  logic                  wr_rise;
  logic                  accept_rd;
  logic [AW-1:0]         req_addr;
  logic                  ram_we;
  logic                  ram_re;
  logic [DW-1:0]         ram_rdata;

  assign rd_rise   = rd & ~rd_q;
  assign wr_rise   = wr & ~wr_q;
  assign req_addr  = sel ? pc_addr : ir_addr;
  // A read arriving together with any write strobe is refused.
  assign accept_rd = rd_rise & ~halt & ~wr;

  // ---------------- state register ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      rd_q     <= rd;
      wr_q     <= wr;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
    end
  end

  // ---------------- next state ----------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_rd) begin
          addr_d = req_addr;
          cnt_d  = WS_INIT;
          state_d = (WAIT_STATES == 0) ? ST_DATA : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!rd) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q <= 1) begin
          // Last wait clock: the RAM is read on the next edge.
          state_d = ST_DATA;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DATA: begin
        if (!rd) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // ---------------- outputs ----------------
  always_comb begin
    // rvalid follows the RAM read register, which loads on the same edge.
    rvalid_d = (state_q == ST_DATA) & rd;
    ram_re   = (state_q == ST_DATA);
    // A store on the reset edge must not reach the RAM.
    ram_we   = wr_rise & data_e & ~halt & ~rst;
    err_d    = err_q | (wr_rise & ~data_e) | (wr_rise & rd_rise);
  end

  cpu_sp_ram #(
    .AW(AW),
    .DW(DW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ir_addr),
    .wdata (wdata),
    .re    (ram_re),
    .raddr (addr_q),
    .rdata (ram_rdata)
  );

  // The RAM output is not reset, so it is masked outside the valid window.
  assign rdata     = rvalid_q ? ram_rdata : '0;
  assign rvalid    = rvalid_q;
  assign busy      = (state_q != ST_IDLE);
  assign err       = err_q;
  assign dbg_state = state_q;

endmodule
